// File: rtl/tlb_pkg.sv
// Shared constants for the joint TLB: entry count, index width and the
// CP0 entry field widths.
package tlb_pkg;

    localparam int TLBNUM   = 16;
    localparam int TLB_IDXW = $clog2(TLBNUM);

    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int PFN_W  = 20;
    localparam int C_W    = 3;

endpackage

// File: rtl/tlb_search_port.sv
// One combinational lookup port: per-entry tag match, lowest-index priority
// select, then even/odd page field select from the winning entry.
module tlb_search_port
    import tlb_pkg::*;
#(
    parameter int TLBNUM = tlb_pkg::TLBNUM,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic [TLBNUM-1:0][VPN2_W-1:0] vpn2_i,
    input  logic [TLBNUM-1:0][ASID_W-1:0] asid_i,
    input  logic [TLBNUM-1:0]             g_i,
    input  logic [TLBNUM-1:0][PFN_W-1:0]  pfn0_i,
    input  logic [TLBNUM-1:0][C_W-1:0]    c0_i,
    input  logic [TLBNUM-1:0]             d0_i,
    input  logic [TLBNUM-1:0]             v0_i,
    input  logic [TLBNUM-1:0][PFN_W-1:0]  pfn1_i,
    input  logic [TLBNUM-1:0][C_W-1:0]    c1_i,
    input  logic [TLBNUM-1:0]             d1_i,
    input  logic [TLBNUM-1:0]             v1_i,
    input  logic [VPN2_W-1:0]             q_vpn2_i,
    input  logic                          q_odd_i,
    input  logic [ASID_W-1:0]             q_asid_i,
    output logic                          found_o,
    output logic [IDXW-1:0]               index_o,
    output logic [PFN_W-1:0]              pfn_o,
    output logic [C_W-1:0]                c_o,
    output logic                          d_o,
    output logic                          v_o
);

    logic [TLBNUM-1:0] match_s;

    // Per-entry tag compare; valid bits deliberately take no part.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            match_s[i] = (vpn2_i[i] == q_vpn2_i) && (g_i[i] || (asid_i[i] == q_asid_i));
        end
    end

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        pfn_o   = '0;
        c_o     = '0;
        d_o     = 1'b0;
        v_o     = 1'b0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                found_o = 1'b1;
                index_o = IDXW'(i);
                if (q_odd_i) begin
                    pfn_o = pfn1_i[i];
                    c_o   = c1_i[i];
                    d_o   = d1_i[i];
                    v_o   = v1_i[i];
                end else begin
                    pfn_o = pfn0_i[i];
                    c_o   = c0_i[i];
                    d_o   = d0_i[i];
                    v_o   = v0_i[i];
                end
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/tlb.sv
// Fully associative joint TLB: entry storage, tlbwi write port, tlbr read
// port and two independent combinational search ports.
module tlb
    import tlb_pkg::*;
#(
    parameter int TLBNUM = tlb_pkg::TLBNUM,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VPN2_W-1:0] s0_vpn2,
    input  logic              s0_odd_page,
    input  logic [ASID_W-1:0] s0_asid,
    output logic              s0_found,
    output logic [IDXW-1:0]   s0_index,
    output logic [PFN_W-1:0]  s0_pfn,
    output logic [C_W-1:0]    s0_c,
    output logic              s0_d,
    output logic              s0_v,
    input  logic [VPN2_W-1:0] s1_vpn2,
    input  logic              s1_odd_page,
    input  logic [ASID_W-1:0] s1_asid,
    output logic              s1_found,
    output logic [IDXW-1:0]   s1_index,
    output logic [PFN_W-1:0]  s1_pfn,
    output logic [C_W-1:0]    s1_c,
    output logic              s1_d,
    output logic              s1_v,
    input  logic              we,
    input  logic [IDXW-1:0]   w_index,
    input  logic [VPN2_W-1:0] w_vpn2,
    input  logic [ASID_W-1:0] w_asid,
    input  logic              w_g,
    input  logic [PFN_W-1:0]  w_pfn0,
    input  logic [C_W-1:0]    w_c0,
    input  logic              w_d0,
    input  logic              w_v0,
    input  logic [PFN_W-1:0]  w_pfn1,
    input  logic [C_W-1:0]    w_c1,
    input  logic              w_d1,
    input  logic              w_v1,
    input  logic [IDXW-1:0]   r_index,
    output logic [VPN2_W-1:0] r_vpn2,
    output logic [ASID_W-1:0] r_asid,
    output logic              r_g,
    output logic [PFN_W-1:0]  r_pfn0,
    output logic [C_W-1:0]    r_c0,
    output logic              r_d0,
    output logic              r_v0,
    output logic [PFN_W-1:0]  r_pfn1,
    output logic [C_W-1:0]    r_c1,
    output logic              r_d1,
    output logic              r_v1
);

    logic [TLBNUM-1:0][VPN2_W-1:0] vpn2_q, vpn2_d;
    logic [TLBNUM-1:0][ASID_W-1:0] asid_q, asid_d;
    logic [TLBNUM-1:0]             g_q, g_d;
    logic [TLBNUM-1:0][PFN_W-1:0]  pfn0_q, pfn0_d, pfn1_q, pfn1_d;
    logic [TLBNUM-1:0][C_W-1:0]    c0_q, c0_d, c1_q, c1_d;
    logic [TLBNUM-1:0]             d0_q, d0_d, v0_q, v0_d;
    logic [TLBNUM-1:0]             d1_q, d1_d, v1_q, v1_d;

    // Next-state: only entry w_index changes, and only on a write.
    always_comb begin
        vpn2_d = vpn2_q;  asid_d = asid_q;  g_d  = g_q;
        pfn0_d = pfn0_q;  c0_d   = c0_q;    d0_d = d0_q;  v0_d = v0_q;
        pfn1_d = pfn1_q;  c1_d   = c1_q;    d1_d = d1_q;  v1_d = v1_q;
        if (we) begin
            vpn2_d[w_index] = w_vpn2;
            asid_d[w_index] = w_asid;
            g_d[w_index]    = w_g;
            pfn0_d[w_index] = w_pfn0;
            c0_d[w_index]   = w_c0;
            d0_d[w_index]   = w_d0;
            v0_d[w_index]   = w_v0;
            pfn1_d[w_index] = w_pfn1;
            c1_d[w_index]   = w_c1;
            d1_d[w_index]   = w_d1;
            v1_d[w_index]   = w_v1;
        end else begin
            g_d = g_q;
        end
    end

    // Entry storage; reset wins over any concurrent write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpn2_q <= '0;  asid_q <= '0;  g_q  <= '0;
            pfn0_q <= '0;  c0_q   <= '0;  d0_q <= '0;  v0_q <= '0;
            pfn1_q <= '0;  c1_q   <= '0;  d1_q <= '0;  v1_q <= '0;
        end else begin
            vpn2_q <= vpn2_d;  asid_q <= asid_d;  g_q  <= g_d;
            pfn0_q <= pfn0_d;  c0_q   <= c0_d;    d0_q <= d0_d;  v0_q <= v0_d;
            pfn1_q <= pfn1_d;  c1_q   <= c1_d;    d1_q <= d1_d;  v1_q <= v1_d;
        end
    end

    assign r_vpn2 = vpn2_q[r_index];
    assign r_asid = asid_q[r_index];
    assign r_g    = g_q[r_index];
    assign r_pfn0 = pfn0_q[r_index];
    assign r_c0   = c0_q[r_index];
    assign r_d0   = d0_q[r_index];
    assign r_v0   = v0_q[r_index];
    assign r_pfn1 = pfn1_q[r_index];
    assign r_c1   = c1_q[r_index];
    assign r_d1   = d1_q[r_index];
    assign r_v1   = v1_q[r_index];

    tlb_search_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_search0 (
        .vpn2_i(vpn2_q), .asid_i(asid_q), .g_i(g_q),
        .pfn0_i(pfn0_q), .c0_i(c0_q), .d0_i(d0_q), .v0_i(v0_q),
        .pfn1_i(pfn1_q), .c1_i(c1_q), .d1_i(d1_q), .v1_i(v1_q),
        .q_vpn2_i(s0_vpn2), .q_odd_i(s0_odd_page), .q_asid_i(s0_asid),
        .found_o(s0_found), .index_o(s0_index), .pfn_o(s0_pfn),
        .c_o(s0_c), .d_o(s0_d), .v_o(s0_v)
    );

    tlb_search_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_search1 (
        .vpn2_i(vpn2_q), .asid_i(asid_q), .g_i(g_q),
        .pfn0_i(pfn0_q), .c0_i(c0_q), .d0_i(d0_q), .v0_i(v0_q),
        .pfn1_i(pfn1_q), .c1_i(c1_q), .d1_i(d1_q), .v1_i(v1_q),
        .q_vpn2_i(s1_vpn2), .q_odd_i(s1_odd_page), .q_asid_i(s1_asid),
        .found_o(s1_found), .index_o(s1_index), .pfn_o(s1_pfn),
        .c_o(s1_c), .d_o(s1_d), .v_o(s1_v)
    );

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: expected values are queued when stimulus is driven
// and popped when the combinational outputs are sampled.
module tb_tlb;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] s0_vpn2, s1_vpn2, w_vpn2, r_vpn2;
    logic        s0_odd_page, s1_odd_page;
    logic [7:0]  s0_asid, s1_asid, w_asid, r_asid;
    logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
    logic [3:0]  s0_index, s1_index, w_index, r_index;
    logic [19:0] s0_pfn, s1_pfn, w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0]  s0_c, s1_c, w_c0, w_c1, r_c0, r_c1;
    logic        we, w_g, w_d0, w_v0, w_d1, w_v1;
    logic        r_g, r_d0, r_v0, r_d1, r_v1;

    logic [29:0] s0_all, s1_all;
    logic [77:0] r_all;

    typedef struct {
        string       tag;
        logic [77:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign s0_all = {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v};
    assign s1_all = {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v};
    assign r_all  = {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};

    tlb dut (
        .clk(clk), .reset(reset),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    task automatic push(input string tag, input logic [77:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [77:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h expected <queued value>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_write(input logic [3:0] idx, input logic [18:0] vpn2,
                             input logic [7:0] asid, input logic g,
                             input logic [19:0] pfn0, input logic [2:0] c0,
                             input logic d0, input logic v0,
                             input logic [19:0] pfn1, input logic [2:0] c1,
                             input logic d1, input logic v1);
        we = 1'b1;  w_index = idx;  w_vpn2 = vpn2;  w_asid = asid;  w_g = g;
        w_pfn0 = pfn0;  w_c0 = c0;  w_d0 = d0;  w_v0 = v0;
        w_pfn1 = pfn1;  w_c1 = c1;  w_d1 = d1;  w_v1 = v1;
    endtask

    task automatic q0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        s0_vpn2 = vpn2;  s0_odd_page = odd;  s0_asid = asid;
    endtask

    task automatic q1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        s1_vpn2 = vpn2;  s1_odd_page = odd;  s1_asid = asid;
    endtask

    initial begin
        reset = 1'b1;
        set_write(4'd0, 19'h0, 8'h0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
        we = 1'b0;
        r_index = 4'd0;
        q0(19'($urandom), 1'b0, 8'($urandom));
        q1(19'($urandom), 1'b1, 8'($urandom));
        #2;
        push("rst_s0", 78'd0);  chk(78'(s0_all));
        push("rst_s1", 78'd0);  chk(78'(s1_all));
        for (int r = 0; r < 16; r++) begin
            r_index = 4'(r);
            #1;
            push($sformatf("rst_rd%0d", r), 78'd0);
            chk(r_all);
        end
        @(negedge clk);
        reset = 1'b0;

        // Write entry 5; same-cycle lookup still sees the old contents.
        q0(19'h12345, 1'b0, 8'h3A);
        set_write(4'd5, 19'h12345, 8'h3A, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                  20'h11111, 3'd2, 1'b0, 1'b0);
        r_index = 4'd5;
        #1;
        push("s0_same_cycle", 78'd0);  chk(78'(s0_all));
        push("rd_same_cycle", 78'd0);  chk(r_all);
        @(negedge clk);
        we = 1'b0;
        #1;
        push("s0_even", 78'({1'b1, 4'd5, 20'hABCDE, 3'd3, 1'b1, 1'b1}));  chk(78'(s0_all));
        s0_odd_page = 1'b1;
        #1;
        push("s0_odd", 78'({1'b1, 4'd5, 20'h11111, 3'd2, 1'b0, 1'b0}));  chk(78'(s0_all));

        push("r_vpn2", 78'h12345);  chk(78'(r_vpn2));
        push("r_asid", 78'h3A);     chk(78'(r_asid));
        push("r_g",    78'd0);      chk(78'(r_g));
        push("r_pfn0", 78'hABCDE);  chk(78'(r_pfn0));
        push("r_c0",   78'd3);      chk(78'(r_c0));
        push("r_d0",   78'd1);      chk(78'(r_d0));
        push("r_v0",   78'd1);      chk(78'(r_v0));
        push("r_pfn1", 78'h11111);  chk(78'(r_pfn1));
        push("r_v1",   78'd0);      chk(78'(r_v1));

        // ASID mismatch misses until the entry is made global.
        q1(19'h12345, 1'b0, 8'h3B);
        #1;
        push("s1_asid_miss", 78'd0);  chk(78'(s1_all));
        @(negedge clk);
        set_write(4'd5, 19'h12345, 8'h3A, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                  20'h11111, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        we = 1'b0;
        #1;
        push("s1_global", 78'({1'b1, 4'd5, 20'hABCDE, 3'd3, 1'b1, 1'b1}));  chk(78'(s1_all));
        push("r_g_set", 78'd1);  chk(78'(r_g));

        // Back-to-back writes to one index: second one sticks.
        @(negedge clk);
        set_write(4'd3, 19'h00777, 8'h10, 1'b0, 20'h00001, 3'd0, 1'b0, 1'b0,
                  20'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        set_write(4'd3, 19'h00777, 8'h10, 1'b0, 20'h00002, 3'd1, 1'b0, 1'b1,
                  20'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        we = 1'b0;
        q0(19'h00777, 1'b0, 8'h10);
        #1;
        push("s0_b2b", 78'({1'b1, 4'd3, 20'h00002, 3'd1, 1'b0, 1'b1}));  chk(78'(s0_all));

        // Duplicate global tags: lowest index wins on both ports.
        set_write(4'd9, 19'h00042, 8'h55, 1'b1, 20'h99999, 3'd5, 1'b0, 1'b1,
                  20'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        we = 1'b0;
        q0(19'h00042, 1'b0, 8'h01);
        q1(19'h00042, 1'b0, 8'h77);
        #1;
        push("s0_hit9", 78'({1'b1, 4'd9, 20'h99999, 3'd5, 1'b0, 1'b1}));  chk(78'(s0_all));
        push("s1_hit9", 78'({1'b1, 4'd9, 20'h99999, 3'd5, 1'b0, 1'b1}));  chk(78'(s1_all));
        @(negedge clk);
        set_write(4'd2, 19'h00042, 8'h66, 1'b1, 20'h22222, 3'd4, 1'b1, 1'b1,
                  20'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        we = 1'b0;
        s1_odd_page = 1'b1;
        #1;
        push("s0_multi", 78'({1'b1, 4'd2, 20'h22222, 3'd4, 1'b1, 1'b1}));  chk(78'(s0_all));
        push("s1_multi_odd", 78'({1'b1, 4'd2, 20'h0, 3'd0, 1'b0, 1'b0}));  chk(78'(s1_all));

        // Reset mid-run with a concurrent write: clears without a clock edge.
        @(negedge clk);
        set_write(4'd7, 19'h05555, 8'h01, 1'b1, 20'h77777, 3'd7, 1'b1, 1'b1,
                  20'h00007, 3'd7, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        push("s0_async_clear", 78'd0);  chk(78'(s0_all));
        @(negedge clk);
        reset = 1'b0;
        we = 1'b0;
        r_index = 4'd7;
        q1(19'h05555, 1'b0, 8'h01);
        q0(19'h12345, 1'b0, 8'h3A);
        #1;
        push("rd7_after_rst", 78'd0);  chk(r_all);
        push("s1_dropped_wr", 78'd0);  chk(78'(s1_all));
        push("s0_old_cleared", 78'd0); chk(78'(s0_all));

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
